beatmap_recorder: RTL and testbench



---
 rtl/beat_pkg.sv | 20 ++
 rtl/beatmap_recorder_if.sv | 25 ++
 rtl/note_tick_gen.sv | 34 +++
 rtl/beatmap_recorder.sv | 145 ++++++++++++++
 tb/tb_beatmap_recorder.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/beat_pkg.sv
// Shared note-lane definitions for the beatmap recorder, renderer and notes memory.
package beat_pkg;

  localparam int unsigned ADDR_W = 13;
  localparam int unsigned NOTE_W = 4;

  // Bit 3 is the leftmost lane, bit 0 the rightmost.
  localparam int unsigned LANE_L  = 3;
  localparam int unsigned LANE_ML = 2;
  localparam int unsigned LANE_MR = 1;
  localparam int unsigned LANE_R  = 0;

  typedef enum logic [1:0] {
    IDLE,
    COUNTIN,
    RECORD,
    DONE
  } state_t;

endpackage

// File: rtl/beatmap_recorder_if.sv
// Key inputs, control pulses, notes-RAM write port and status of the beatmap recorder.
interface beatmap_recorder_if;
  import beat_pkg::*;

  logic [NOTE_W-1:0] keys;
  logic              start;
  logic              stop;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [NOTE_W-1:0] wr_data;
  logic              recording;
  logic              done;
  logic [ADDR_W-1:0] length;

  modport master (
    input  keys, start, stop,
    output wr_en, wr_addr, wr_data, recording, done, length
  );

  modport slave (
    output keys, start, stop,
    input  wr_en, wr_addr, wr_data, recording, done, length
  );

endinterface

// File: rtl/note_tick_gen.sv
// Free-running note-rate counter; tick is high for the last cycle of each interval.
module note_tick_gen #(
  parameter int unsigned TICK_CYCLES = 5000000
) (
  input  logic clk,
  input  logic resetn,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CntW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TICK_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    if (restart || cnt_q == CntLast) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == CntLast);

endmodule

// File: rtl/beatmap_recorder.sv
// Records synchronised lane presses into the notes RAM, one word per note tick.
// Optional count-in before recording is enabled by defining BEATMAP_COUNTIN_EN.
module beatmap_recorder
  import beat_pkg::*;
#(
  parameter int unsigned DEPTH         = 8192,
  parameter int unsigned TICK_CYCLES   = 5000000,
  parameter int unsigned COUNTIN_TICKS = 8
) (
  input logic                clk,
  input logic                resetn,
  beatmap_recorder_if.master bus
);

  if (DEPTH == 0 || DEPTH > 2 ** ADDR_W) begin : g_bad_depth
    $error("DEPTH must be in 1..2**ADDR_W");
  end
  if (COUNTIN_TICKS == 0) begin : g_bad_countin
    $error("COUNTIN_TICKS must be at least 1");
  end

  // One extra bit so a full take of 2**ADDR_W words is representable internally.
  localparam logic [ADDR_W:0] LenLast = (ADDR_W + 1)'(DEPTH - 1);

  state_t            state_q, state_d;
  logic [NOTE_W-1:0] sync_q, ks_q;
  logic [NOTE_W-1:0] sticky_q, sticky_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [NOTE_W-1:0] wr_data_q, wr_data_d;
  logic              restart;
  logic              tick;

`ifdef BEATMAP_COUNTIN_EN
  localparam int unsigned CinW = $clog2(COUNTIN_TICKS + 1);
  localparam logic [CinW-1:0] CinLast = CinW'(COUNTIN_TICKS - 1);
  logic [CinW-1:0] cin_q, cin_d;
`endif

  note_tick_gen #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_tick (
    .clk    (clk),
    .resetn (resetn),
    .restart(restart),
    .tick   (tick)
  );

  always_comb begin
    state_d   = state_q;
    sticky_d  = sticky_q;
    len_d     = len_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    restart   = 1'b0;
`ifdef BEATMAP_COUNTIN_EN
    cin_d     = cin_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          restart  = 1'b1;
          len_d    = '0;
          sticky_d = '0;
`ifdef BEATMAP_COUNTIN_EN
          cin_d    = '0;
          state_d  = COUNTIN;
`else
          state_d  = RECORD;
`endif
        end
      end
`ifdef BEATMAP_COUNTIN_EN
      COUNTIN: begin
        sticky_d = '0;
        if (bus.stop) begin
          state_d = DONE;
        end else if (tick) begin
          if (cin_q == CinLast) begin
            state_d = RECORD;
          end else begin
            cin_d = cin_q + 1'b1;
          end
        end
      end
`endif
      RECORD: begin
        sticky_d = sticky_q | ks_q;
        if (tick) begin
          // The tick-cycle sample is folded into the word and sticky restarts empty.
          wr_en_d   = 1'b1;
          wr_addr_d = len_q[ADDR_W-1:0];
          wr_data_d = sticky_q | ks_q;
          len_d     = len_q + 1'b1;
          sticky_d  = '0;
          if (bus.stop || len_q == LenLast) begin
            state_d = DONE;
          end
        end else if (bus.stop) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      sync_q    <= '0;
      ks_q      <= '0;
      sticky_q  <= '0;
      len_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
`ifdef BEATMAP_COUNTIN_EN
      cin_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      sync_q    <= bus.keys;
      ks_q      <= sync_q;
      sticky_q  <= sticky_d;
      len_q     <= len_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
`ifdef BEATMAP_COUNTIN_EN
      cin_q     <= cin_d;
`endif
    end
  end

  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.recording = (state_q == RECORD) || (state_q == COUNTIN);
  assign bus.done      = (state_q == DONE);
  // A full 2**ADDR_W take cannot be shown in ADDR_W bits, so it reads as all-ones.
  assign bus.length    = len_q[ADDR_W] ? '1 : len_q[ADDR_W-1:0];

endmodule

// File: tb/tb_beatmap_recorder.sv
// Directed self-checking bench for beatmap_recorder (TICK_CYCLES=4, DEPTH=8, COUNTIN_TICKS=2).
module tb_beatmap_recorder;
  import beat_pkg::*;

  logic clk = 1'b0;
  logic resetn;
  int   total = 0;
  int   bad   = 0;

  beatmap_recorder_if bus ();

  beatmap_recorder #(
    .DEPTH        (8),
    .TICK_CYCLES  (4),
    .COUNTIN_TICKS(2)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // n cycles with no write strobe at all
  task automatic quiet(input string tag, input int n);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      step();
      if (bus.wr_en !== 1'b0) seen = 1'b1;
    end
    chk({tag, "_quiet"}, 32'(seen), 32'd0);
  endtask

  task automatic write_now(input string tag, input int addr, input logic [3:0] data);
    step();
    chk({tag, "_en"}, 32'(bus.wr_en), 32'd1);
    chk({tag, "_addr"}, 32'(bus.wr_addr), 32'(addr));
    chk({tag, "_data"}, 32'(bus.wr_data), 32'(data));
  endtask

  task automatic expect_write(input string tag, input int gap, input int addr,
                              input logic [3:0] data);
    quiet(tag, gap - 1);
    write_now(tag, addr, data);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
  endtask

  initial begin
    resetn    = 1'b0;
    bus.keys  = 4'b0000;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    step(3);
    chk("rst_wr_en", 32'(bus.wr_en), 32'd0);
    chk("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
    chk("rst_wr_data", 32'(bus.wr_data), 32'd0);
    chk("rst_recording", 32'(bus.recording), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_length", 32'(bus.length), 32'd0);
    resetn = 1'b1;
    step(2);

`ifdef BEATMAP_COUNTIN_EN
    // Count-in: two silent ticks, first write on the third.
    bus.keys = 4'b1111;
    step(3);
    pulse_start();
    chk("t6_recording", 32'(bus.recording), 32'd1);
    expect_write("t6_w0", 12, 0, 4'b1111);
    chk("t6_length", 32'(bus.length), 32'd1);
`else
    // Held key fills the whole take, then auto-stop.
    bus.keys = 4'b1000;
    step(3);
    pulse_start();
    chk("t1_recording", 32'(bus.recording), 32'd1);
    for (int a = 0; a < 8; a++) expect_write("t1_w", 4, a, 4'b1000);
    chk("t1_done", 32'(bus.done), 32'd1);
    chk("t1_recording_off", 32'(bus.recording), 32'd0);
    chk("t1_length", 32'(bus.length), 32'd8);
    quiet("t1_no9th", 8);

    // One-cycle press is held by sticky until the next tick only.
    bus.keys = 4'b0000;
    step(3);
    pulse_start();
    chk("t2_done_clr", 32'(bus.done), 32'd0);
    chk("t2_length0", 32'(bus.length), 32'd0);
    bus.keys = 4'b0010;
    step();
    bus.keys = 4'b0000;
    expect_write("t2_w0", 3, 0, 4'b0010);
    expect_write("t2_w1", 4, 1, 4'b0000);
    expect_write("t2_w2", 4, 2, 4'b0000);
    step();
    pulse_stop();
    chk("t2_done", 32'(bus.done), 32'd1);
    chk("t2_length", 32'(bus.length), 32'd3);
    quiet("t2_after", 6);

    // Stop coincident with the third tick still writes that word.
    bus.keys = 4'b0101;
    step(3);
    pulse_start();
    expect_write("t3_w0", 4, 0, 4'b0101);
    expect_write("t3_w1", 4, 1, 4'b0101);
    quiet("t3_pre", 3);
    bus.stop = 1'b1;
    write_now("t3_w2", 2, 4'b0101);
    bus.stop = 1'b0;
    chk("t3_done", 32'(bus.done), 32'd1);
    chk("t3_length", 32'(bus.length), 32'd3);
    quiet("t3_after", 8);
    pulse_stop();
    chk("t3_stop_in_done", 32'(bus.done), 32'd1);
    chk("t3_length_held", 32'(bus.length), 32'd3);

    // Reset on a tick edge mid-take suppresses that write.
    bus.keys = 4'b0001;
    step(3);
    pulse_start();
    expect_write("t4_w0", 4, 0, 4'b0001);
    expect_write("t4_w1", 4, 1, 4'b0001);
    quiet("t4_pre", 3);
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    chk("t4_wr_en", 32'(bus.wr_en), 32'd0);
    chk("t4_wr_addr", 32'(bus.wr_addr), 32'd0);
    chk("t4_wr_data", 32'(bus.wr_data), 32'd0);
    chk("t4_recording", 32'(bus.recording), 32'd0);
    chk("t4_done", 32'(bus.done), 32'd0);
    chk("t4_length", 32'(bus.length), 32'd0);
    quiet("t4_idle", 6);

    // Stop in IDLE and start during RECORD are both ignored.
    pulse_stop();
    chk("t5_idle_rec", 32'(bus.recording), 32'd0);
    chk("t5_idle_done", 32'(bus.done), 32'd0);
    step(2);
    pulse_start();
    expect_write("t5_w0", 4, 0, 4'b0001);
    step();
    pulse_start();
    chk("t5_still_rec", 32'(bus.recording), 32'd1);
    expect_write("t5_w1", 2, 1, 4'b0001);
    expect_write("t5_w2", 4, 2, 4'b0001);
    step();
    pulse_stop();
    chk("t5_done", 32'(bus.done), 32'd1);
    chk("t5_length", 32'(bus.length), 32'd3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
